// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder: parallel-to-serial word feeder with a one-word holding register for gapless streaming
module serial_bit_feeder #(
  parameter int WIDTH = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             bit_en,
  output logic             out_bit,
  output logic             out_valid,
  output logic             out_last,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] shift_reg, shift_n, hold_reg, hold_n, shifted;
  logic [CW-1:0] bit_cnt, cnt_n;
  logic hold_full, hold_full_n, accept, consume, last;
  assign in_ready  = !rst && !hold_full;
  assign accept    = in_valid && in_ready;
  assign out_valid = !rst && state == SHIFT;
  assign consume   = out_valid && bit_en;
  assign last      = bit_cnt == CW'(WIDTH - 1);
  assign out_last  = out_valid && last;
  assign out_bit   = out_valid && (MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0]);
  assign busy      = !rst && (state == SHIFT || hold_full);
  assign shifted   = MSB_FIRST ? {shift_reg[WIDTH-2:0], 1'b0} : {1'b0, shift_reg[WIDTH-1:1]};
  // next-state: load from idle, refill from hold or input on word end, otherwise shift and park incoming words
  always_comb begin
    state_n = state;
    shift_n = shift_reg;
    cnt_n = bit_cnt;
    hold_n = hold_reg;
    hold_full_n = hold_full;
    if (state == IDLE) begin
      if (accept) begin
        state_n = SHIFT;
        shift_n = in_data;
        cnt_n = '0;
      end
    end else if (consume && last) begin
      if (hold_full) begin
        shift_n = hold_reg;
        cnt_n = '0;
        hold_full_n = accept;
        hold_n = accept ? in_data : hold_reg;
      end else if (accept) begin
        shift_n = in_data;
        cnt_n = '0;
      end else begin
        state_n = IDLE;
      end
    end else begin
      shift_n = consume ? shifted : shift_reg;
      cnt_n = consume ? bit_cnt + CW'(1) : bit_cnt;
      hold_n = accept ? in_data : hold_reg;
      hold_full_n = hold_full || accept;
    end
  end
  // state register with synchronous reset discarding any in-flight or held word
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      shift_reg <= '0;
      bit_cnt <= '0;
      hold_reg <= '0;
      hold_full <= 1'b0;
    end else begin
      state <= state_n;
      shift_reg <= shift_n;
      bit_cnt <= cnt_n;
      hold_reg <= hold_n;
      hold_full <= hold_full_n;
    end
  end
endmodule
